acs_pmu_pipe: RTL and testbench
===============================

Name: acs_pmu_pipe

Overview:
- Parametrised, registered Add-Compare-Select plus path-metric unit for rate-1/2 convolutional Viterbi decoding, with any constraint length K.
- Holds the path-metric (PM) register internally, applies per-transition branch metrics from the BMU, and emits one survivor-decision word per trellis step to the traceback/survivor memory.
- Adds over the fixed 4-state ACSU: frame control, valid/ready handshakes, argmin tracking, saturation, and optional min-subtraction normalization.

Parameters:
- K, 3: constraint length; NS = 2^(K-1) states.
- G0, 7: generator polynomial for output bit c0 (K bits, MSB = newest input).
- G1, 5: generator polynomial for output bit c1.
- BM_WIDTH, 2: branch metric width.
- PM_WIDTH, 8: path metric width.
- INIT_PM, 64: initial PM of all states except state 0 at frame start.
- NORM_THRESH, 128: normalization threshold (used only when ACS_NORM_EN is defined).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- in_valid_i, in, 1: input beat valid.
- in_ready_o, out, 1: input beat accepted when in_valid_i && in_ready_o.
- sof_i, in, 1: beat is the first step of a frame.
- eof_i, in, 1: beat is the last step of a frame.
- bm_vec_i, in, 4*BM_WIDTH: branch metric for codeword c at [c*BM_WIDTH +: BM_WIDTH], with c = {c0,c1} and c0 as MSB.
- out_valid_o, out, 1: decision beat valid.
- out_ready_i, in, 1: downstream accepts the decision beat.
- dec_bits_o, out, NS: decision bit per next state; 0 = predecessor p0, 1 = predecessor p1.
- best_state_o, out, K-1: index of the minimum new PM (lowest index wins ties).
- best_pm_o, out, PM_WIDTH: value of the minimum new PM.
- out_sof_o, out, 1: sof flag aligned to the decision beat.
- out_eof_o, out, 1: eof flag aligned to the decision beat.
- norm_o, out, 1: normalization was applied on this beat.
- pm_flat_o, out, NS*PM_WIDTH: current PM register; state s at [s*PM_WIDTH +: PM_WIDTH].

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0; dec_bits_o, best_state_o, best_pm_o, out_sof_o, out_eof_o and norm_o all 0; PM register all 0; FSM in IDLE. A reset mid-frame discards everything in flight. No output appears until the next sof beat.
- Trellis: next state ns = {u, s[K-2:1]}. Predecessors of ns are p0 = {ns[K-3:0],0} and p1 = {ns[K-3:0],1}; the input bit is u = ns[K-2]. Transition register r = {u, s}; c0 = ^(r & G0), c1 = ^(r & G1).
- ADD: cand = pm[p] + bm[c], computed at PM_WIDTH+1 bits and clamped to 2^PM_WIDTH-1.
- Compare/select: ties resolve to p0 (dec = 0).
- Start-of-frame beat: the PM source is the initial vector (state 0 = 0, all others = INIT_PM), not the PM register.
- Handshake: in_ready_o = !out_valid_o || out_ready_i (single output register stage, one-cycle latency, no bubbles at full throughput). On an accepted beat:
  - the PM register and output register update in the same edge;
  - out_valid_o rises the next cycle.
- While out_valid_o && !out_ready_i, all outputs and the PM register hold stable.
- FSM:
  - IDLE: in_ready_o = 1. Beats without sof_i are consumed and dropped; no output, PM unchanged. An accepted sof beat is processed and moves the FSM to RUN (or stays in IDLE if eof_i is also set).
  - RUN: every accepted beat is processed. A sof beat re-initializes the PMs (frame restart). An accepted eof beat is processed and returns the FSM to IDLE.
- best_state_o, best_pm_o and pm_flat_o reflect post-normalization values.

Optional Feature:
- Macro ACS_NORM_EN.
- Defined: if the minimum new PM ≥ NORM_THRESH, subtract that minimum from every new PM in the same cycle and pulse norm_o=1 for that beat. Saturated values are also reduced.
- Undefined: PMs only saturate at 2^PM_WIDTH-1; norm_o is tied to 0.

Test Plan (all tests use default parameters):
- Reset and idle drop: reset, then 3 beats with sof_i=0 → no out_valid_o, pm_flat_o stays all 0.
- First step: sof beat with bm{00,01,10,11} = {0,1,1,2} → next cycle out_valid_o=1, dec_bits_o=4'b0000, PM {s0..s3} = {0,65,2,65}, best_state_o=0, best_pm_o=0, out_sof_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles with in_valid_i=1 → in_ready_o=0 and outputs/PM frozen. Release → each beat is emitted exactly once, in order.
- Normalization (ACS_NORM_EN defined): sof beat followed by beats with all bm = 3 → at beat 43 (minimum 129) norm_o=1 and best_pm_o=0. Without the macro: PMs saturate at 255 and norm_o stays 0.
- Frame control: an eof beat returns the FSM to IDLE (out_eof_o=1), so a following non-sof beat is dropped. A mid-frame sof restores PM = {0,64,64,64} before ADD. Asserting rst_i mid-frame clears out_valid_o immediately.

Source files
------------

// File: rtl/acs_pmu_pipe.sv
// Registered add-compare-select / path-metric unit for rate-1/2 Viterbi decoding, any K.
// Optional min-subtraction normalization is enabled by defining ACS_NORM_EN.
module acs_pmu_pipe #(
  parameter int K           = 3,
  parameter int G0          = 7,
  parameter int G1          = 5,
  parameter int BM_WIDTH    = 2,
  parameter int PM_WIDTH    = 8,
  parameter int INIT_PM     = 64,
  parameter int NORM_THRESH = 128
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              sof_i,
  input  logic                              eof_i,
  input  logic [4*BM_WIDTH-1:0]             bm_vec_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [(1<<(K-1))-1:0]             dec_bits_o,
  output logic [K-2:0]                      best_state_o,
  output logic [PM_WIDTH-1:0]               best_pm_o,
  output logic                              out_sof_o,
  output logic                              out_eof_o,
  output logic                              norm_o,
  output logic [(1<<(K-1))*PM_WIDTH-1:0]    pm_flat_o
);

  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam logic [K-1:0]        G0_M    = K'(G0);
  localparam logic [K-1:0]        G1_M    = K'(G1);
  localparam logic [PM_WIDTH-1:0] PM_MAX  = '1;
  localparam logic [PM_WIDTH-1:0] PM_INIT = PM_WIDTH'(INIT_PM);

`ifdef ACS_NORM_EN
  localparam bit NORM_ON = 1'b1;
`else
  localparam bit NORM_ON = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;
  logic   accept, proc_en;

  logic [BM_WIDTH-1:0] bm      [4];
  logic [PM_WIDTH-1:0] pm_src  [NS];
  logic [PM_WIDTH-1:0] cand0   [NS];
  logic [PM_WIDTH-1:0] cand1   [NS];
  logic [PM_WIDTH-1:0] pm_acs  [NS];
  logic [PM_WIDTH-1:0] pm_new  [NS];
  logic [NS-1:0]       dec_acs;
  logic [PM_WIDTH-1:0] min_pm;
  logic [SW-1:0]       min_idx;
  logic                norm_hit;

  logic [PM_WIDTH-1:0] pm_q [NS], pm_d [NS];
  logic                out_valid_q, out_valid_d;
  logic [NS-1:0]       dec_q, dec_d;
  logic [SW-1:0]       best_state_q, best_state_d;
  logic [PM_WIDTH-1:0] best_pm_q, best_pm_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eof_q, out_eof_d;
  logic                norm_q, norm_d;

  // Trellis: predecessor b of next state ns, and the codeword on that branch.
  function automatic logic [SW-1:0] pred_of(input logic [SW-1:0] ns, input logic b);
    return {ns[SW-2:0], b};
  endfunction

  function automatic logic [1:0] cw_of(input logic [SW-1:0] ns, input logic b);
    logic [K-1:0] r;
    r = {ns[SW-1], pred_of(ns, b)};
    return {^(r & G0_M), ^(r & G1_M)};
  endfunction

  function automatic logic [PM_WIDTH-1:0] sat_add(input logic [PM_WIDTH-1:0] pm,
                                                 input logic [BM_WIDTH-1:0] bmv);
    logic [PM_WIDTH:0] sum;
    sum = {1'b0, pm} + (PM_WIDTH+1)'(bmv);
    return sum[PM_WIDTH] ? PM_MAX : sum[PM_WIDTH-1:0];
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (sof_i && !eof_i) state_d = RUN;
        RUN:     if (eof_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
  always_comb begin
    in_ready_o = !out_valid_q || out_ready_i;
    accept     = in_valid_i && in_ready_o;
    proc_en    = accept && ((state_q == RUN) || sof_i);
  end

  // Add-compare-select, argmin and optional normalization
  always_comb begin
    for (int c = 0; c < 4; c++) bm[c] = bm_vec_i[c*BM_WIDTH +: BM_WIDTH];
    for (int s = 0; s < NS; s++) pm_src[s] = sof_i ? ((s == 0) ? '0 : PM_INIT) : pm_q[s];

    dec_acs = '0;
    for (int n = 0; n < NS; n++) begin
      cand0[n]   = sat_add(pm_src[pred_of(SW'(n), 1'b0)], bm[cw_of(SW'(n), 1'b0)]);
      cand1[n]   = sat_add(pm_src[pred_of(SW'(n), 1'b1)], bm[cw_of(SW'(n), 1'b1)]);
      dec_acs[n] = cand1[n] < cand0[n];
      pm_acs[n]  = dec_acs[n] ? cand1[n] : cand0[n];
    end

    // Strict compare keeps the lowest index on ties.
    min_pm  = pm_acs[0];
    min_idx = '0;
    for (int n = 1; n < NS; n++) begin
      if (pm_acs[n] < min_pm) begin
        min_pm  = pm_acs[n];
        min_idx = SW'(n);
      end
    end

    norm_hit = NORM_ON && (int'(min_pm) >= NORM_THRESH);
    for (int n = 0; n < NS; n++) pm_new[n] = norm_hit ? (pm_acs[n] - min_pm) : pm_acs[n];
  end

  // Next register values: load on a processed beat, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_ready_i) out_valid_d = 1'b0;
    if (proc_en)     out_valid_d = 1'b1;

    dec_d        = proc_en ? dec_acs : dec_q;
    best_state_d = proc_en ? min_idx : best_state_q;
    best_pm_d    = proc_en ? (norm_hit ? '0 : min_pm) : best_pm_q;
    out_sof_d    = proc_en ? sof_i : out_sof_q;
    out_eof_d    = proc_en ? eof_i : out_eof_q;
    norm_d       = proc_en ? norm_hit : norm_q;
    for (int s = 0; s < NS; s++) pm_d[s] = proc_en ? pm_new[s] : pm_q[s];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  // NOTE: the PM register is a handful of flops, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      dec_q        <= '0;
      best_state_q <= '0;
      best_pm_q    <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      norm_q       <= 1'b0;
      for (int s = 0; s < NS; s++) pm_q[s] <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      dec_q        <= dec_d;
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      norm_q       <= norm_d;
      for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
    end
  end

  always_comb begin
    out_valid_o  = out_valid_q;
    dec_bits_o   = dec_q;
    best_state_o = best_state_q;
    best_pm_o    = best_pm_q;
    out_sof_o    = out_sof_q;
    out_eof_o    = out_eof_q;
    norm_o       = norm_q;
    pm_flat_o    = '0;
    for (int s = 0; s < NS; s++) pm_flat_o[s*PM_WIDTH +: PM_WIDTH] = pm_q[s];
  end

endmodule

// File: tb/tb_acs_pmu_pipe.sv
// Directed bench for acs_pmu_pipe (default parameters, K=3, G=7/5); covers both
// builds of ACS_NORM_EN for the normalization/saturation sequence.
module tb_acs_pmu_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        sof_i;
  logic        eof_i;
  logic [7:0]  bm_vec_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  dec_bits_o;
  logic [1:0]  best_state_o;
  logic [7:0]  best_pm_o;
  logic        out_sof_o;
  logic        out_eof_o;
  logic        norm_o;
  logic [31:0] pm_flat_o;

  acs_pmu_pipe dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .bm_vec_i     (bm_vec_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .dec_bits_o   (dec_bits_o),
    .best_state_o (best_state_o),
    .best_pm_o    (best_pm_o),
    .out_sof_o    (out_sof_o),
    .out_eof_o    (out_eof_o),
    .norm_o       (norm_o),
    .pm_flat_o    (pm_flat_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] hs_q [$];

  // Output handshakes, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (out_valid_o && out_ready_i) hs_q.push_back(pm_flat_o);
  end

  typedef struct {
    logic        sof;
    logic        eof;
    logic [7:0]  bm;
    logic        exp_valid;
    logic        chk_data;
    logic [3:0]  exp_dec;
    logic [31:0] exp_pm;
    logic [1:0]  exp_bs;
    logic [7:0]  exp_bpm;
    logic        exp_sof;
    logic        exp_eof;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic sof, input logic eof, input logic [7:0] bm);
    in_valid_i = 1'b1;
    sof_i      = sof;
    eof_i      = eof;
    bm_vec_i   = bm;
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0;
    sof_i      = 1'b0;
    eof_i      = 1'b0;
    bm_vec_i   = 8'h00;
  endtask

  logic [31:0] exp_pm;
  logic [7:0]  exp_bpm;
  logic        exp_norm;

  initial begin
    // bm_vec = {bm11, bm10, bm01, bm00}, 2 bits each; pm_flat = {s3, s2, s1, s0}.
    vecs[0]  = '{1'b0, 1'b0, 8'h94, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'd0, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'd0, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 4'b0000, 32'h00000000, 2'd0, 8'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h94, 1'b1, 1'b1, 4'b0000, 32'h41024100, 2'd0, 8'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h72, 1'b1, 1'b1, 4'b0000, 32'h02010502, 2'd2, 8'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 4'b0010, 32'h01020205, 2'd3, 8'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h49, 1'b1, 1'b1, 4'b1101, 32'h01030203, 2'd3, 8'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'b1111, 32'h01020102, 2'd1, 8'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h94, 1'b0, 1'b0, 4'b0000, 32'h01020102, 2'd0, 8'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h94, 1'b1, 1'b1, 4'b0000, 32'h41024100, 2'd0, 8'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 32'h40004000, 2'd0, 8'd0, 1'b1, 1'b0};

    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    idle_in();
    repeat (2) tick();
    check("rst valid",    out_valid_o, 0);
    check("rst pm",       pm_flat_o, 0);
    check("rst dec",      dec_bits_o, 0);
    check("rst bstate",   best_state_o, 0);
    check("rst bpm",      best_pm_o, 0);
    check("rst sof/eof",  {out_sof_o, out_eof_o}, 0);
    check("rst norm",     norm_o, 0);
    check("rst in_ready", in_ready_o, 1);
    rst_i = 1'b0;
    tick();

    // Idle drop, one full frame, drop after eof, frame start and mid-frame restart.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].sof, vecs[i].eof, vecs[i].bm);
      tick();
      check($sformatf("row%0d valid", i), out_valid_o, vecs[i].exp_valid);
      check($sformatf("row%0d pm", i), pm_flat_o, vecs[i].exp_pm);
      if (vecs[i].chk_data) begin
        check($sformatf("row%0d dec", i), dec_bits_o, vecs[i].exp_dec);
        check($sformatf("row%0d bstate", i), best_state_o, vecs[i].exp_bs);
        check($sformatf("row%0d bpm", i), best_pm_o, vecs[i].exp_bpm);
        check($sformatf("row%0d sof", i), out_sof_o, vecs[i].exp_sof);
        check($sformatf("row%0d eof", i), out_eof_o, vecs[i].exp_eof);
        check($sformatf("row%0d norm", i), norm_o, 0);
      end
    end
    idle_in();
    tick();
    hs_q.delete();

    // Backpressure: outputs and PM freeze, then every beat comes out once, in order.
    out_ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h94);
    tick();
    check("bp first valid", out_valid_o, 1);
    drive(1'b0, 1'b0, 8'h72);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp stall%0d in_ready", c), in_ready_o, 0);
      check($sformatf("bp stall%0d valid", c), out_valid_o, 1);
      check($sformatf("bp stall%0d pm", c), pm_flat_o, 32'h41024100);
      check($sformatf("bp stall%0d sof", c), out_sof_o, 1);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp beat2 pm", pm_flat_o, 32'h02010502);
    check("bp beat2 sof", out_sof_o, 0);
    drive(1'b0, 1'b1, 8'h33);
    tick();
    check("bp beat3 pm", pm_flat_o, 32'h01020205);
    check("bp beat3 eof", out_eof_o, 1);
    idle_in();
    tick();
    check("bp drained valid", out_valid_o, 0);
    check("bp handshake count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("bp order0", hs_q[0], 32'h41024100);
      check("bp order1", hs_q[1], 32'h02010502);
      check("bp order2", hs_q[2], 32'h01020205);
    end

    // All branch metrics 3: beat n>=2 gives 3n in every state.
    for (int n = 1; n <= 90; n++) begin
      drive(n == 1, n == 90, 8'hFF);
      tick();
      if (n == 1) begin
        check("norm beat1 pm", pm_flat_o, 32'h43034303);
        check("norm beat1 bpm", best_pm_o, 3);
      end
      if (n == 42 || n == 43 || n == 85 || n == 86 || n == 90) begin
`ifdef ACS_NORM_EN
        if (n < 43)      begin exp_bpm = 8'(3*n);      exp_norm = 1'b0; end
        else if (n < 86) begin exp_bpm = 8'(3*(n-43)); exp_norm = 1'b0; end
        else             begin exp_bpm = 8'(3*(n-86)); exp_norm = 1'b0; end
        if (n == 43 || n == 86) exp_norm = 1'b1;
`else
        exp_bpm  = (3*n > 255) ? 8'd255 : 8'(3*n);
        exp_norm = 1'b0;
`endif
        exp_pm = {4{exp_bpm}};
        check($sformatf("norm beat%0d pm", n), pm_flat_o, exp_pm);
        check($sformatf("norm beat%0d bpm", n), best_pm_o, exp_bpm);
        check($sformatf("norm beat%0d bstate", n), best_state_o, 0);
        check($sformatf("norm beat%0d norm", n), norm_o, exp_norm);
      end
    end
    idle_in();
    tick();

    // Reset mid-frame clears the output immediately; the FSM restarts in IDLE.
    drive(1'b1, 1'b0, 8'h94);
    tick();
    check("mrst pre valid", out_valid_o, 1);
    drive(1'b0, 1'b0, 8'h72);
    #2;
    rst_i = 1'b1;
    #1;
    check("mrst valid", out_valid_o, 0);
    check("mrst pm", pm_flat_o, 0);
    check("mrst dec", dec_bits_o, 0);
    #1;
    rst_i = 1'b0;
    tick();
    check("mrst drop valid", out_valid_o, 0);
    check("mrst drop pm", pm_flat_o, 0);
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
